// File: rtl/fa_serial.sv
// rtl/fa_serial.sv - bit-serial adder built from one full-adder cell and a carry flip-flop
//
// Computes {co,s} = a + b + ci one bit per clock, LSB first.
// Optional feature macro: FA_SERIAL_OVF_EN adds the registered signed-overflow output ovf.
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request one addition (ignored while busy)
//   a, b   in   WIDTH  unsigned operands, captured on the accepting edge
//   ci     in   1      carry-in, captured with the operands
//   s      out  WIDTH  registered sum, held until the next result
//   co     out  1      registered carry-out
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle pulse when s/co are freshly loaded
//   ovf    out  1      two's-complement overflow (FA_SERIAL_OVF_EN only)
module fa_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             busy,
  output logic             done
`ifdef FA_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  // areg doubles as the sum shift register: operand bits leave at the LSB
  // while sum bits enter at the MSB, so after WIDTH shifts it holds the sum.
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic             carry;
  logic             sum_bit;
  logic             carry_nx;
  logic             last_bit;

  // the single one-bit full-adder cell
  assign sum_bit  = areg[0] ^ breg[0] ^ carry;
  assign carry_nx = (areg[0] & breg[0]) | (carry & (areg[0] ^ breg[0]));
  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = start ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      areg  <= '0;
      breg  <= '0;
      carry <= 1'b0;
      s     <= '0;
      co    <= 1'b0;
`ifdef FA_SERIAL_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            areg  <= a;
            breg  <= b;
            carry <= ci;
            cnt   <= '0;
          end
        end
        RUN: begin
          areg  <= {sum_bit, areg[WIDTH-1:1]};
          breg  <= breg >> 1;
          carry <= carry_nx;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            s  <= {sum_bit, areg[WIDTH-1:1]};
            co <= carry_nx;
`ifdef FA_SERIAL_OVF_EN
            // on the MSB step, carry is the carry into the MSB
            ovf <= carry ^ carry_nx;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fa_serial.sv
// tb/tb_fa_serial.sv - self-checking bench for fa_serial (WIDTH=4)
module tb_fa_serial;

  localparam int W = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         ci    = 1'b0;
  logic [W-1:0] s;
  logic         co;
  logic         busy;
  logic         done;
`ifdef FA_SERIAL_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fa_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .s     (s),
    .co    (co),
    .busy  (busy),
    .done  (done)
`ifdef FA_SERIAL_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit signed_ovf(input int av, input int bv, input int cv);
    int sa, sb, t;
    sa = (av >= 2 ** (W - 1)) ? av - 2 ** W : av;
    sb = (bv >= 2 ** (W - 1)) ? bv - 2 ** W : bv;
    t  = sa + sb + cv;
    return (t > 2 ** (W - 1) - 1) || (t < -(2 ** (W - 1)));
  endfunction

  // Behavioural model: an accepted request yields a+b+ci exactly W edges later.
  int         cyc = 0;
  int         m_due = 0;
  bit         m_busy = 1'b0;
  bit         m_done = 1'b0;
  int         m_pend = 0;
  int         m_res = 0;
  bit         m_ovf_pend = 1'b0;
  bit         m_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_res  = 0;
      m_ovf  = 1'b0;
    end else begin
      cyc++;
      m_done = 1'b0;
      if (m_busy && cyc == m_due) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_res  = m_pend;
        m_ovf  = m_ovf_pend;
      end else if (!m_busy && start) begin
        m_pend     = int'(a) + int'(b) + int'(ci);
        m_ovf_pend = signed_ovf(int'(a), int'(b), int'(ci));
        m_due      = cyc + W;
        m_busy     = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("busy_vs_model", busy, m_busy);
    check("done_vs_model", done, m_done);
    check("s_vs_model", s, m_res % (2 ** W));
    check("co_vs_model", co, m_res / (2 ** W));
`ifdef FA_SERIAL_OVF_EN
    check("ovf_vs_model", ovf, m_ovf);
`endif
  end

  task automatic run_op(input int va, input int vb, input int vc, input int es, input int eco,
                        input int eovf, input bit chg);
    int  lat, busy_cnt;
    bit  got;
    lat = -1; busy_cnt = 0; got = 1'b0;
    @(negedge clk);
    a = W'(va); b = W'(vb); ci = vc[0]; start = 1'b1;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0;
        if (chg) begin a = ~a; b = ~b; ci = ~ci; end
      end
      if (busy) busy_cnt++;
      if (done) begin
        got = 1'b1;
        lat = i - 1;
        check("op_s", s, es);
        check("op_co", co, eco);
`ifdef FA_SERIAL_OVF_EN
        check("op_ovf", ovf, eovf);
`else
        if (eovf > 1) $display("unused ovf expectation");
`endif
      end
    end
    check("op_latency", lat, W);
    check("op_busy_cycles", busy_cnt, W);
  endtask

  initial begin
    int done_idx[$];
    bit saw_done;

    // async reset with no clock edge involved
    #2 rst_n = 1'b0;
    #1;
    check("rst_s", s, 0);
    check("rst_co", co, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 3+5: 0011+0101 = 1000, carry into MSB without carry out -> overflow
    run_op(3, 5, 0, 8, 0, 1, 1'b0);
    check("model_pin_3p5", m_res, 8);
    @(negedge clk);

    // wrap-around, operands flipped during RUN must not matter
    run_op(15, 15, 1, 15, 1, 0, 1'b1);
    check("model_pin_wrap", m_res, 31);
    @(negedge clk);

    // continuous start: one result every W+1 cycles
    a = 4'd1; b = 4'd1; ci = 1'b0; start = 1'b1;
    for (int i = 1; i <= 26; i++) begin
      @(negedge clk);
      if (done) begin
        done_idx.push_back(i);
        check("stream_s", s, 2);
      end
    end
    start = 1'b0;
    check("stream_count", done_idx.size(), 5);
    for (int i = 1; i < done_idx.size(); i++)
      check("stream_period", done_idx[i] - done_idx[i-1], W + 1);
    for (int i = 0; i < 6; i++) @(negedge clk);

    // reset two cycles into RUN aborts with no done pulse
    a = 4'd7; b = 4'd9; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_s", s, 0);
    check("abort_co", co, 0);
    check("abort_busy", busy, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 0);
    run_op(7, 9, 0, 0, 1, 0, 1'b0);
    check("model_pin_7p9", m_res, 16);

    // exhaustive sweep against the combinational adder
    for (int vc = 0; vc < 2; vc++)
      for (int va = 0; va < 16; va++)
        for (int vb = 0; vb < 16; vb++)
          run_op(va, vb, vc, (va + vb + vc) % 16, (va + vb + vc) / 16,
                 signed_ovf(va, vb, vc), 1'b0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fa_serial.md
FA_SERIAL -- requirements
Module: fa_serial

Interface
REQ-001 Parameter: WIDTH, default 4, operand and sum width in bits (legal 2..16).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request one addition; sampled on the clk rising edge.
REQ-005 Port: a  input  WIDTH  operand A, unsigned.
REQ-006 Port: b  input  WIDTH  operand B, unsigned.
REQ-007 Port: ci  input  1  carry-in.
REQ-008 Port: s  output  WIDTH  registered sum.
REQ-009 Port: co  output  1  registered carry-out.
REQ-010 Port: busy  output  1  high while bits are being processed.
REQ-011 Port: done  output  1  one-cycle pulse; s and co are valid.
REQ-012 Port: ovf  output  1  signed overflow flag; present only with FA_SERIAL_OVF_EN.

Function
REQ-013 The block SHALL compute {co,s} = a + b + ci bit-serially, LSB first, using a single one-bit full-adder cell and a carry flip-flop.
REQ-014 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-015 IDLE or DONE with start=1 at edge k: capture a, b and ci into internal shift/carry registers, clear the bit counter, go to RUN, and set busy=1 from edge k.
REQ-016 RUN: each edge SHALL add one bit pair plus the carry, shift the sum bit into the sum shift register at the MSB end, update the carry, and increment the counter.
REQ-017 After WIDTH RUN edges (edge k+WIDTH), the block SHALL go to DONE, load s and co, set busy=0 and set done=1.
REQ-018 Latency SHALL be exactly WIDTH cycles from the start-sampling edge to done=1; throughput SHALL be one result per WIDTH+1 cycles.
REQ-019 DONE SHALL last one cycle: go to RUN if start=1, otherwise go to IDLE.
REQ-020 done SHALL be high only in DONE.
REQ-021 s and co SHALL hold their last result until the next DONE; they SHALL NOT change during RUN.
REQ-022 start while in RUN SHALL be ignored, and the operation in progress SHALL complete unchanged.
REQ-023 Changes on a, b or ci after the capture edge SHALL have no effect on the result.
REQ-024 Wrap-around: the all-ones operands with ci=1 SHALL give s = all-ones and co=1 with no error indication.
REQ-025 The counter SHALL be ceil(log2(WIDTH+1)) bits wide, and the counter value SHALL never exceed WIDTH.

Reset
REQ-026 rst_n=0 SHALL immediately, independent of clk, force state=IDLE and clear s, co, busy, done, ovf, the counter and all shift/carry registers to 0.
REQ-027 Reset during RUN SHALL abort the operation with no done pulse; the first start after release SHALL behave as from power-up.
REQ-028 Release of rst_n SHALL be honoured on the first clk rising edge at which rst_n is sampled high.

Configuration
REQ-029 Macro FA_SERIAL_OVF_EN SHALL control the overflow feature.
REQ-030 With FA_SERIAL_OVF_EN defined: port ovf SHALL exist and SHALL be registered in DONE as (carry into MSB) XOR (carry out of MSB), i.e. two's-complement overflow; it SHALL hold with s and reset to 0.
REQ-031 Without FA_SERIAL_OVF_EN: port ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=4)
REQ-032 Reset, then start with a=3, b=5, ci=0 -> busy high for 4 cycles, done pulses at start edge +4, s=8, co=0, ovf=1 (macro on).
REQ-033 a=15, b=15, ci=1 -> s=15, co=1, ovf=0; change a and b during RUN -> result unchanged.
REQ-034 start held high continuously with a=1, b=1, ci=0 -> done every 5 cycles with s=2 each time; mid-RUN start ignored.
REQ-035 rst_n low 2 cycles into RUN of a=7, b=9 -> outputs 0 immediately, no done pulse; next start with a=7, b=9, ci=0 -> s=0, co=1.
REQ-036 Exhaustive sweep of all 512 {ci,a,b} combinations -> {co,s} matches a+b+ci for each, compared against the combinational 4-bit adder golden model.
